// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (port A) beats a FIFO of
// long-latency results (port B); a busy scoreboard tracks pending port-B writes.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy,
  output logic        wb_stall,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } b_entry_t;

  b_entry_t    mem_q [DEPTH];
  b_entry_t    head;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        full, empty, push, pop;

  logic [3:0]  starve_q, starve_d;
  logic        wb_stall_q, wb_stall_d;
  logic        err_q, err_d;
  logic [31:0] busy_q, busy_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  // The extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign b_ready = !full && !rst;
  assign push    = b_valid && b_ready;
  assign pop     = !a_valid && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    if (a_valid) begin
      rf_we_d    = (a_reg != 5'd0);
      rf_waddr_d = a_reg;
      rf_wdata_d = a_data;
    end else if (pop) begin
      rf_we_d    = (head.rd != 5'd0);
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      busy_d[head.rd] = 1'b0;
    end
    // A new issue to the register being retired this cycle must stay busy.
    if (issue_valid && issue_reg != 5'd0) busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;

    if (empty || pop)           starve_d = 4'd0;
    else if (starve_q != 4'hF)  starve_d = starve_q + 4'd1;
    else                        starve_d = starve_q;
    wb_stall_d = (starve_d >= 4'(STARVE_LIMIT));

    err_d = err_q
          | (issue_valid && issue_reg != 5'd0 && busy_q[issue_reg])
          | (a_valid && wb_stall_q)
          | (b_valid && !b_ready);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= 4'd0;
      wb_stall_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{rd: b_reg, data: b_data};
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign wb_stall = wb_stall_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_reg, b_reg, issue_reg;
  logic [31:0] a_data, b_data;
  logic        b_ready, rf_we, wb_stall, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .wb_stall(wb_stall), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ir);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    issue_valid = iv; issue_reg = ir;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        bv; logic [4:0] br; logic [31:0] bd;
    logic        iv; logic [4:0] ir;
    logic        we; logic ca; logic [4:0] wa; logic [31:0] wd;
    logic [31:0] bz; logic rdy; logic st; logic er;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic bv, input logic [4:0] br, input logic [31:0] bd,
    input logic iv, input logic [4:0] ir,
    input logic we, input logic ca, input logic [4:0] wa, input logic [31:0] wd,
    input logic [31:0] bz, input logic rdy, input logic st, input logic er);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.iv = iv; v.ir = ir; v.we = we; v.ca = ca; v.wa = wa; v.wd = wd;
    v.bz = bz; v.rdy = rdy; v.st = st; v.er = er;
    return v;
  endfunction

  vec_t vecs [13];

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          m_wait;
  logic        m_stall, m_err, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_q.delete();
    m_busy = '0; m_wait = 0; m_stall = 1'b0; m_err = 1'b0;
    m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   ready, had_entry, popped;
    ent_t h;
    ready     = (m_q.size() < DEPTH);
    had_entry = (m_q.size() > 0);
    popped    = 1'b0;
    if (issue_valid && issue_reg != 5'd0 && m_busy[issue_reg]) m_err = 1'b1;
    if (a_valid && m_stall)   m_err = 1'b1;
    if (b_valid && !ready)    m_err = 1'b1;
    m_we = 1'b0;
    if (a_valid) begin
      m_we = (a_reg != 5'd0); m_waddr = a_reg; m_wdata = a_data;
    end else if (had_entry) begin
      h = m_q.pop_front();
      popped = 1'b1;
      m_we = (h.rd != 5'd0); m_waddr = h.rd; m_wdata = h.data;
      if (h.rd != 5'd0) m_busy[h.rd] = 1'b0;
    end
    if (issue_valid && issue_reg != 5'd0) m_busy[issue_reg] = 1'b1;
    if (popped || !had_entry) m_wait = 0;
    else if (m_wait < 15)     m_wait = m_wait + 1;
    m_stall = (m_wait >= LIMIT);
    if (b_valid && ready) m_q.push_back('{rd: b_reg, data: b_data});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.rf_we",    32'(rf_we),    32'd0);
    check("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst.rf_wdata", rf_wdata,      32'd0);
    check("rst.busy",     busy,          32'd0);
    check("rst.wb_stall", 32'(wb_stall), 32'd0);
    check("rst.err",      32'(err),      32'd0);
    check("rst.b_ready",  32'(b_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.b_ready", 32'(b_ready), 32'd1);

    // A write, B round trip through the scoreboard, register-0 writes and issues.
    vecs[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7,
                  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h80, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h80, 1'b1, 1'b0, 1'b0);
    vecs[4]  = vecs[3];
    vecs[5]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0,
                  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h80, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b1, 1'b1, 5'd7, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b0, 1'b1, 5'd7, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b0, 1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0,
                  1'b0, 1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0,
                  1'b0, 1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                  1'b0, 1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[12] = vecs[11];

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd,
            vecs[i].iv, vecs[i].ir);
      cycle();
      check($sformatf("vec%0d.rf_we", i),    32'(rf_we),    32'(vecs[i].we));
      if (vecs[i].ca) begin
        check($sformatf("vec%0d.rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].wa));
        check($sformatf("vec%0d.rf_wdata", i), rf_wdata,      vecs[i].wd);
      end
      check($sformatf("vec%0d.busy", i),     busy,          vecs[i].bz);
      check($sformatf("vec%0d.b_ready", i),  32'(b_ready),  32'(vecs[i].rdy));
      check($sformatf("vec%0d.wb_stall", i), 32'(wb_stall), 32'(vecs[i].st));
      check($sformatf("vec%0d.err", i),      32'(err),      32'(vecs[i].er));
    end

    // Starvation: A hogs the port while one B entry waits.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h9999, 1'b0, 5'd0);
    cycle();
    check("starve.a_addr", 32'(rf_waddr), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      drive(1'b1, 5'd2, 32'(w), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      cycle();
      check($sformatf("starve.w%0d.wb_stall", w), 32'(wb_stall), (w == 4) ? 32'd1 : 32'd0);
    end
    idle();
    cycle();
    check("starve.b_we",     32'(rf_we),    32'd1);
    check("starve.b_addr",   32'(rf_waddr), 32'd9);
    check("starve.b_data",   rf_wdata,      32'h9999);
    check("starve.wb_stall", 32'(wb_stall), 32'd0);
    check("starve.err",      32'(err),      32'd0);

    // Overflow: two pushes fill the FIFO, a third is dropped and flags err.
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
    cycle();
    check("ovf.c0.b_ready", 32'(b_ready), 32'd1);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'hA1, 1'b0, 5'd0);
    cycle();
    check("ovf.c1.b_ready", 32'(b_ready), 32'd0);
    check("ovf.c1.err",     32'(err),     32'd0);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hA2, 1'b0, 5'd0);
    cycle();
    check("ovf.c2.err", 32'(err), 32'd1);
    idle();
    cycle();
    check("ovf.d0.addr", 32'(rf_waddr), 32'd10);
    check("ovf.d0.data", rf_wdata,      32'hA0);
    check("ovf.d0.we",   32'(rf_we),    32'd1);
    cycle();
    check("ovf.d1.addr", 32'(rf_waddr), 32'd11);
    check("ovf.d1.data", rf_wdata,      32'hA1);
    check("ovf.d1.err",  32'(err),      32'd1);
    cycle();
    check("ovf.d2.we", 32'(rf_we), 32'd0);

    // Asynchronous reset with a full FIFO and a busy register.
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd20, 32'hB0, 1'b1, 5'd3);
    cycle();
    check("mid.busy", busy, 32'h8);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd21, 32'hB1, 1'b0, 5'd0);
    cycle();
    check("mid.b_ready", 32'(b_ready), 32'd0);
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst.rf_we",    32'(rf_we),    32'd0);
    check("arst.rf_waddr", 32'(rf_waddr), 32'd0);
    check("arst.rf_wdata", rf_wdata,      32'd0);
    check("arst.busy",     busy,          32'd0);
    check("arst.err",      32'(err),      32'd0);
    check("arst.wb_stall", 32'(wb_stall), 32'd0);
    check("arst.b_ready",  32'(b_ready),  32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst.rel.b_ready", 32'(b_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("arst.idle%0d.rf_we", k), 32'(rf_we), 32'd0);
      check($sformatf("arst.idle%0d.busy", k),  busy,        32'd0);
    end

    // Randomized traffic against the reference model, reset between segments.
    for (int seg = 0; seg < 8; seg++) begin
      idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 250; c++) begin
        logic av, bv, iv;
        logic [4:0] ir;
        av = m_stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
        bv = ($urandom_range(0, 9) < 4);
        if (bv && m_q.size() >= DEPTH && $urandom_range(0, 9) != 0) bv = 1'b0;
        ir = 5'($urandom);
        iv = ($urandom_range(0, 4) == 0);
        if (iv && m_busy[ir] && $urandom_range(0, 9) != 0) iv = 1'b0;
        drive(av, 5'($urandom), $urandom, bv, 5'($urandom), $urandom, iv, ir);
        model_step();
        cycle();
        check($sformatf("rnd%0d.%0d.rf_we", seg, c),    32'(rf_we),    32'(m_we));
        check($sformatf("rnd%0d.%0d.rf_waddr", seg, c), 32'(rf_waddr), 32'(m_waddr));
        check($sformatf("rnd%0d.%0d.rf_wdata", seg, c), rf_wdata,      m_wdata);
        check($sformatf("rnd%0d.%0d.busy", seg, c),     busy,          m_busy);
        check($sformatf("rnd%0d.%0d.b_ready", seg, c),  32'(b_ready),  32'(m_q.size() < DEPTH));
        check($sformatf("rnd%0d.%0d.wb_stall", seg, c), 32'(wb_stall), 32'(m_stall));
        check($sformatf("rnd%0d.%0d.err", seg, c),      32'(err),      32'(m_err));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file in the pipelined core. It shares the register file's single write port between the in-order pipeline writeback (port A, never back-pressured) and a long-latency unit such as mult/div or a load miss (port B, valid/ready). Port B results are buffered in a small FIFO. A busy scoreboard tells decode which registers still await a port-B result. All register-file write-port signals are registered; the register file captures them on its falling-edge write.

## Interface
Parameters:
- DEPTH, 2: port-B FIFO entries (power of two, 2..8)
- STARVE_LIMIT, 4: cycles a FIFO head may wait before wb_stall asserts (1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  pipeline writeback request
- a_reg  in  5  destination register for port A
- a_data  in  32  write data for port A
- b_valid  in  1  long-latency result valid
- b_reg  in  5  destination register for port B
- b_data  in  32  write data for port B
- b_ready  out  1  FIFO not full; 0 while rst is high
- issue_valid  in  1  decode issued a long-latency op
- issue_reg  in  5  its destination register
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- busy  out  32  scoreboard, one bit per register
- wb_stall  out  1  request: pipeline must hold a_valid low next cycle
- err  out  1  sticky protocol-violation flag

## Operation
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, wb_stall=0, err=0, FIFO empty, starve counter 0.
  - Reset mid-operation discards all FIFO entries and clears all busy bits immediately (asynchronous).
- Port A is always accepted.
  - If a_valid=1 in cycle N: rf_we=1, rf_waddr=a_reg, rf_wdata=a_data in cycle N+1.
  - If a_reg=0, the request is consumed but rf_we stays 0.
- Port B push occurs when b_valid && b_ready.
  - b_ready = !full (combinational from FIFO occupancy).
  - Pushed entries drain in FIFO order.
- Arbitration each cycle, in priority order:
  - a_valid=1: A wins.
  - else FIFO non-empty: the head pops and drives the write port next cycle.
  - else rf_we=0 next cycle; rf_waddr and rf_wdata hold their previous values.
- A popped head with b_reg=0 gives rf_we=0 and clears no busy bit.
- Scoreboard:
  - issue_valid with issue_reg!=0 sets busy[issue_reg] at the next edge.
  - A port-B pop for register r clears busy[r] at the same edge that registers rf_we.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is always 0.
- Starvation:
  - A 4-bit counter increments each cycle the FIFO is non-empty and the head is not popped.
  - The counter clears on a pop or when the FIFO is empty.
  - When counter >= STARVE_LIMIT, wb_stall=1 (registered). wb_stall drops the cycle after the head pops.
- err is set, and held until reset, on any of:
  - issue_valid to a register already busy (WAW not permitted),
  - a_valid=1 in a cycle where wb_stall=1 (A still wins),
  - b_valid=1 while b_ready=0 (the push is dropped).

## Timing
- Port A latency: 1 cycle from a_valid sample to rf_we.
- Port B minimum latency: 2 cycles (push at edge N, head pops at edge N+1, rf_we high in cycle N+2).
- Simultaneous push and pop when full: b_ready reflects the pre-pop full state, so the push is refused.
- Simultaneous push and pop with the FIFO non-full and non-empty: both occur; occupancy is unchanged.
- Throughput: one register-file write per cycle maximum.
- Worst-case wait for port B with a well-behaved pipeline: STARVE_LIMIT+2 cycles.
- Read pointer, write pointer and occupancy wrap modulo DEPTH; the full/empty distinction uses an extra pointer bit.

## Test plan
- Reset, then a_valid=1, a_reg=5, a_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- issue_valid with issue_reg=7, then 3 cycles later b_valid with b_reg=7, b_data=0x1234 and a idle -> busy[7]=1 from the cycle after issue; rf_we with addr 7 two cycles after the push; busy[7]=0 at that same edge.
- a_valid held 1 continuously with one B entry queued (STARVE_LIMIT=4) -> wb_stall=1 after 4 waiting cycles; drop a_valid -> B written next cycle, wb_stall back to 0, err=0.
- Push 2 B entries (DEPTH=2) while A is busy -> b_ready=0; a third b_valid sets err=1 and is dropped; the two entries later drain in push order.
- Writes with a_reg=0 and b_reg=0, plus issue_valid with issue_reg=0 -> rf_we never asserts; busy stays 0.
- Assert rst for one cycle with 2 entries queued and busy[3]=1 -> all outputs return to reset values, FIFO empty, b_ready=1 after rst falls, no stale write occurs.
